// File: rtl/wb_burst_master_if.sv
// Command, write-data and response streams plus the Wishbone initiator bus
// of wb_burst_master. The master modport is the burst master's view.
interface wb_burst_master_if #(
    parameter int LEN_W = 4
);
    // command stream
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [31:0]      cmd_adr;
    logic [3:0]       cmd_sel;
    logic [LEN_W-1:0] cmd_len;
    // write beat data stream
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;
    // per-beat response stream
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_last;
    logic             rsp_err;
    // Wishbone classic initiator
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic             wbm_ack_i;
    logic [31:0]      wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
        input  wr_valid, wr_data,
        input  rsp_ready,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready, wr_ready,
        output rsp_valid, rsp_data, rsp_last, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
        output wr_valid, wr_data,
        output rsp_ready,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready, wr_ready,
        input  rsp_valid, rsp_data, rsp_last, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst initiator: one command becomes 1..2**LEN_W
// incrementing single-beat strobes under one cyc, one response per beat.
// A slave that never acks is abandoned after TIMEOUT strobe cycles.
module wb_burst_master #(
    parameter int TIMEOUT = 64,
    parameter int LEN_W   = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_burst_master_if.master bus,
    output logic              busy
);
    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WDATA, REQ, RESP} state_t;

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_last_q, rsp_last_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    // Every output comes straight from a flop.
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign busy          = busy_q;

    // Next-state and next-output decode; registered outputs are computed here.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        wr_ready_d  = wr_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        len_d       = len_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    we_d        = bus.cmd_we;
                    adr_d       = bus.cmd_adr;
                    sel_d       = bus.cmd_sel;
                    len_d       = bus.cmd_len;
                    beat_d      = '0;
                    tmo_d       = '0;
                    dat_d       = '0;
                    cmd_ready_d = 1'b0;
                    if (bus.cmd_we) begin
                        state_d    = WDATA;
                        wr_ready_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (bus.wr_valid) begin
                    dat_d      = bus.wr_data;
                    wr_ready_d = 1'b0;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    tmo_d      = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // ack is checked first so an ack on the final allowed cycle still succeeds
                if (bus.wbm_ack_i) begin
                    rsp_data_d  = we_q ? 32'd0 : bus.wbm_dat_i;
                    rsp_last_d  = (beat_q == len_q);
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        cyc_d       = 1'b0;
                        cmd_ready_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        adr_d  = adr_q + 32'd4;
                        beat_d = beat_q + 1'b1;
                        tmo_d  = '0;
                        if (we_q) begin
                            wr_ready_d = 1'b1;
                            state_d    = WDATA;
                        end else begin
                            stb_d   = 1'b1;
                            state_d = REQ;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: a delayed-ack Wishbone slave,
// random stream stalls, and a per-command reference of the expected
// strobes and responses derived from the command and per-beat slave delays.
module tb_wb_burst_master;
    localparam int TIMEOUT = 64;
    localparam int LEN_W   = 4;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          len;
    } pulse_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        err;
        logic        cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    wb_burst_master_if #(.LEN_W(LEN_W)) bus ();

    wb_burst_master #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave read data is a fixed function of the address.
    function automatic logic [31:0] rdata(input logic [31:0] a);
        if (a == 32'h3800_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Per-command stimulus: slave ack delay per beat (0 = never ack) and write data.
    int          delays [16];
    logic [31:0] wd     [16];

    // Slave / monitor state.
    pulse_t pulses[$];
    rsp_t   rsps[$];
    pulse_t cur;
    int     cur_len   = 0;
    int     cur_delay = 0;
    int     pulse_idx = 0;
    logic   noise     = 1'b0;
    logic   cmd_done  = 1'b0;

    // Ack arrives in the cur_delay-th strobe cycle; spurious acks while stb is low.
    assign bus.wbm_ack_i = bus.wbm_stb_o ? (cur_delay != 0 && cur_len == cur_delay - 1) : noise;
    assign bus.wbm_dat_i = bus.wbm_stb_o ? rdata(bus.wbm_adr_o) : 32'hBAD0_BAD0;

    // Record every strobe pulse: attributes at its first cycle and its length.
    always @(posedge clk) begin
        noise <= ($urandom_range(3) == 0);
        if (rst) begin
            cur_len <= 0;
        end else if (bus.cmd_valid && bus.cmd_ready) begin
            pulses.delete();
            pulse_idx <= 0;
            cur_delay <= delays[0];
            cur_len   <= 0;
        end else if (bus.wbm_stb_o) begin
            if (cur_len == 0)
                cur <= '{adr: bus.wbm_adr_o, we: bus.wbm_we_o, sel: bus.wbm_sel_o,
                         dat: bus.wbm_dat_o, len: 0};
            cur_len <= cur_len + 1;
        end else if (cur_len > 0) begin
            pulses.push_back('{adr: cur.adr, we: cur.we, sel: cur.sel, dat: cur.dat, len: cur_len});
            pulse_idx <= pulse_idx + 1;
            cur_delay <= (pulse_idx < 15) ? delays[pulse_idx + 1] : 0;
            cur_len   <= 0;
        end
    end

    // Reference: walk the beats, stop at the first one whose slave never acks.
    task automatic check_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel, input int len);
        pulse_t      ep[$];
        rsp_t        er[$];
        logic [31:0] a = adr;
        int          n;
        for (int b = 0; b <= len; b++) begin
            ep.push_back('{adr: a, we: we, sel: sel, dat: we ? wd[b] : 32'd0,
                           len: (delays[b] == 0) ? TIMEOUT : delays[b]});
            if (delays[b] == 0) begin
                er.push_back('{data: 32'd0, last: 1'b1, err: 1'b1, cyc: 1'b0});
                break;
            end
            er.push_back('{data: we ? 32'd0 : rdata(a), last: (b == len), err: 1'b0, cyc: 1'b1});
            a = a + 32'd4;
        end
        check("n_strobes", 32'(pulses.size()), 32'(ep.size()));
        check("n_rsps", 32'(rsps.size()), 32'(er.size()));
        n = (pulses.size() < ep.size()) ? pulses.size() : ep.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("adr[%0d]", i), pulses[i].adr, ep[i].adr);
            check($sformatf("we[%0d]", i), 32'(pulses[i].we), 32'(ep[i].we));
            check($sformatf("sel[%0d]", i), 32'(pulses[i].sel), 32'(ep[i].sel));
            check($sformatf("dat_o[%0d]", i), pulses[i].dat, ep[i].dat);
            check($sformatf("stb_cycles[%0d]", i), 32'(pulses[i].len), 32'(ep[i].len));
        end
        n = (rsps.size() < er.size()) ? rsps.size() : er.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("rsp_data[%0d]", i), rsps[i].data, er[i].data);
            check($sformatf("rsp_last[%0d]", i), 32'(rsps[i].last), 32'(er[i].last));
            check($sformatf("rsp_err[%0d]", i), 32'(rsps[i].err), 32'(er[i].err));
            check($sformatf("rsp_cyc[%0d]", i), 32'(rsps[i].cyc), 32'(er[i].cyc));
        end
    endtask

    // Issue one command; rst_beat >= 0 resets during that strobe, hold > 0
    // stalls the first response for that many cycles.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input int len, input int rst_beat, input int hold);
        int n = 0;
        rsps.delete();
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_sel   = sel;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("cmd_ready_taken", 32'(bus.cmd_ready), 32'd0);
        check("busy_taken", 32'(busy), 32'd1);
        check("stb_first", 32'(bus.wbm_stb_o), 32'(!we));
        check("wr_ready_first", 32'(bus.wr_ready), 32'(we));
        cmd_done = 1'b0;
        fork
            begin : writer
                if (we) begin
                    for (int b = 0; b <= len; b++) begin
                        if (cmd_done) break;
                        repeat ($urandom_range(2)) @(negedge clk);
                        bus.wr_valid = 1'b1;
                        bus.wr_data  = wd[b];
                        while (!bus.wr_ready && !cmd_done) @(negedge clk);
                        if (cmd_done) break;
                        @(posedge clk);
                        #1;
                        bus.wr_valid = 1'b0;
                    end
                    bus.wr_valid = 1'b0;
                end
            end
            begin : consumer
                int   cycles = 0;
                logic held   = 1'b0;
                logic rdy;
                logic [31:0] snap;
                while (!cmd_done) begin
                    @(negedge clk);
                    cycles++;
                    if (cycles > 3000) begin
                        check("cmd_cycle_budget", 32'd0, 32'd1);
                        cmd_done = 1'b1;
                        break;
                    end
                    rdy = ($urandom_range(3) != 0);
                    if (hold > 0 && !held && bus.rsp_valid && rsps.size() == 0) begin
                        held = 1'b1;
                        snap = bus.rsp_data;
                        bus.rsp_ready = 1'b0;
                        repeat (hold) begin
                            @(negedge clk);
                            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                            check("hold_rsp_data", bus.rsp_data, snap);
                            check("hold_no_stb", 32'(bus.wbm_stb_o), 32'd0);
                        end
                        rdy = 1'b1;
                    end
                    bus.rsp_ready = rdy;
                    if (bus.rsp_valid && rdy) begin
                        rsps.push_back('{data: bus.rsp_data, last: bus.rsp_last,
                                         err: bus.rsp_err, cyc: bus.wbm_cyc_o});
                        @(posedge clk);
                        #1;
                        bus.rsp_ready = 1'b0;
                        if (rsps[rsps.size() - 1].last) cmd_done = 1'b1;
                    end
                end
                bus.rsp_ready = 1'b0;
            end
            begin : resetter
                if (rst_beat >= 0) begin
                    int w = 0;
                    @(negedge clk);
                    while (!(bus.wbm_stb_o && pulse_idx == rst_beat) && w < 2000) begin
                        @(negedge clk);
                        w++;
                    end
                    check("rst_reached_beat", 32'(w < 2000), 32'd1);
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
                    check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
                    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
                    check("rst_busy", 32'(busy), 32'd0);
                    cmd_done = 1'b1;
                end
            end
        join
        if (rst_beat < 0) begin
            check_cmd(we, adr, sel, len);
            check("end_cyc", 32'(bus.wbm_cyc_o), 32'd0);
            check("end_busy", 32'(busy), 32'd0);
            check("end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        end
    endtask

    task automatic fill(input int d);
        for (int i = 0; i < 16; i++) begin
            delays[i] = d;
            wd[i]     = $urandom;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_sel   = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rsp_ready = 1'b0;
        fill(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("reset_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("reset_adr", bus.wbm_adr_o, 32'd0);
        check("reset_rsp_data", bus.rsp_data, 32'd0);
        rst = 1'b0;

        // single read with a 10-cycle ack
        fill(1); delays[0] = 10;
        run_cmd(1'b0, 32'h3800_0010, 4'hF, 0, -1, 0);

        // four-beat write burst
        fill(1);
        delays[0] = 3; delays[1] = 1; delays[2] = 7; delays[3] = 10;
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        run_cmd(1'b1, 32'h3800_0000, 4'hF, 3, -1, 0);

        // hung slave on beat 0 of a read: abort, remaining beats dropped
        fill(2); delays[0] = 0;
        run_cmd(1'b0, 32'h3800_0100, 4'hF, 2, -1, 0);

        // ack on the last allowed cycle wins over the timeout
        fill(2); delays[0] = TIMEOUT;
        run_cmd(1'b0, 32'h3800_0200, 4'h3, 0, -1, 0);

        // hung slave on beat 1 of a write
        fill(2); delays[1] = 0;
        run_cmd(1'b1, 32'h3800_0300, 4'hC, 3, -1, 0);

        // first response of a two-beat read held for 20 cycles
        fill(4);
        run_cmd(1'b0, 32'h3800_0400, 4'hF, 1, -1, 20);

        // address wraps past 0xFFFF_FFFC
        fill(2); delays[1] = 3;
        run_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 1, -1, 0);

        // reset during beat 1 of a four-beat write, then a clean command
        fill(10);
        run_cmd(1'b1, 32'h3800_0500, 4'hF, 3, 1, 0);
        fill(2);
        run_cmd(1'b1, 32'h3800_0600, 4'hA, 1, -1, 0);

        // random commands
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic        w;
            fill(1);
            for (int i = 0; i < 16; i++)
                delays[i] = ($urandom_range(19) == 0) ? 0 : int'($urandom_range(1, 6));
            a = $urandom;
            a[1:0] = 2'b00;
            if (k % 8 == 7) a = 32'hFFFF_FFF0;
            w = 1'($urandom_range(1));
            run_cmd(w, a, 4'($urandom), int'($urandom_range(15)), -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone classic-cycle initiator. Turns single commands into 1–16 beat incrementing read or write sequences on a 32-bit Wishbone bus.
- Drives user-project slaves that insert multi-cycle ack delay, e.g. the BRAM slave at 0x38xx_xxxx with its 10-cycle ack.
- Sits between a local command/data stream (LA- or firmware-driven) and the wishbone slave port; returns one response per beat.
- Aborts a hung slave via an ack timeout.

Parameters:
- TIMEOUT, 64: max cycles stb may stay high without ack before abort (≥2).
- LEN_W, 4: width of cmd_len; beats = cmd_len+1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  32  first beat byte address
- cmd_sel  in  4  byte lanes, used for all beats
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat data offered
- wr_ready  out  1  write data accepted when wr_valid&wr_ready
- wr_data  in  32  write beat data
- rsp_valid  out  1  beat response available
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read data; 0 for writes and errors
- rsp_last  out  1  final response of command
- rsp_err  out  1  beat timed out
- busy  out  1  not IDLE
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone select
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data; 0 during reads
- wbm_ack_i  in  1  Wishbone ack
- wbm_dat_i  in  32  Wishbone read data

Behaviour:
- All outputs registered.
- Reset (sampled at the clock edge): state=IDLE; all outputs 0 except cmd_ready=1; beat and timeout counters cleared.
- Reset mid-operation: cyc/stb drop at the next edge. The in-flight beat and the rest of the command are discarded; no response is issued.
- States: IDLE, WDATA, REQ, RESP.
- IDLE: cmd_ready=1. On handshake, latch we/adr/sel/len, clear beat count, cmd_ready→0. Go to WDATA if write, else REQ.
- WDATA: wr_ready=1, cyc held at its current value, stb=0. On wr_valid, latch wr_data into wbm_dat_o and go to REQ.
- REQ: cyc=1, stb=1, we/adr/sel/dat stable. The timeout counter increments each cycle.
  - ack=1: capture wbm_dat_i (read) or 0 (write) into rsp_data; stb→0; go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: cyc→0, stb→0, rsp_err=1, rsp_last=1, rsp_data=0; go to RESP.
  - ack and timeout in the same cycle: ack wins, no error.
- RESP: rsp_valid=1 and stable until rsp_ready.
  - rsp_last=1 when beat==len or err.
  - On consume: if last, cyc→0 and go to IDLE. Otherwise adr+=4 (mod 2^32 wrap), beat+=1, timeout counter cleared; go to WDATA (write) or REQ (read).
- cyc stays high across all beats of a successful command and drops only after the last response is consumed or on error. stb is low between beats, so the slave restarts its ack delay each beat.
- wbm_ack_i is ignored when stb=0.
- Latency:
  - Read: cmd handshake at edge N → stb high after edge N. Ack sampled at edge M → rsp_valid high after edge M.
  - Write: adds one cycle per beat for the WDATA handshake (minimum).
- A new command is accepted no earlier than the cycle after the final response is consumed.
- busy = (state != IDLE).

Test Plan:
- Read, cmd_adr=0x3800_0010, len=0, slave acks 10 cycles after stb with dat=0xDEAD_BEEF → stb high 10 cycles; one rsp_valid with rsp_data=0xDEAD_BEEF, rsp_last=1, rsp_err=0; cyc low after consume.
- Write burst, adr=0x3800_0000, len=3, wr_data 0x11,0x22,0x33,0x44, sel=0xF → four stb pulses at adr 0x..00/04/08/0C with matching dat_o; cyc high throughout; 4 responses, only the 4th with rsp_last.
- Slave never acks, TIMEOUT=64 → stb high exactly 64 cycles; rsp_err=1, rsp_last=1, rsp_data=0; cyc low; returns to IDLE with the remaining beats dropped. Ack on cycle 64 exactly → no error.
- rsp_ready held low 20 cycles on beat 1 of a 2-beat read → rsp_valid/rsp_data stable; no second stb until consumed.
- Read burst at adr=0xFFFF_FFFC, len=1 → second beat address 0x0000_0000.
- wb_rst_i pulsed during beat 2 of a 4-beat write → cyc/stb/rsp_valid=0 and cmd_ready=1 after the edge; the next command executes normally from beat 0.
